// File: rtl/align_shifter_pipe.sv
// rtl/align_shifter_pipe.sv - pipelined left/right barrel shifter with sticky and valid/ready flow
// One 2:1 mux level per shift-amount bit; PIPE_MASK[k] puts a register after level k.
module align_shifter_pipe #(
  parameter int                SW        = 26,
  parameter int                LEVELS    = 5,
  parameter logic [LEVELS-1:0] PIPE_MASK = 5'b10101
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [SW-1:0]     data_i,
  input  logic [LEVELS-1:0] shamt_i,
  input  logic              dir_i,
  input  logic              arith_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [SW-1:0]     data_o,
  output logic              sticky_o
);

  // Beat state at each level boundary: index k feeds level k, index LEVELS is the output.
  logic [SW-1:0]     b_data   [0:LEVELS];
  logic              b_sticky [0:LEVELS];
  logic [LEVELS-1:0] b_shamt  [0:LEVELS];
  logic              b_dir    [0:LEVELS];
  logic              b_fill   [0:LEVELS];
  logic              b_valid  [0:LEVELS];
  logic              b_ready  [0:LEVELS];

  assign b_data[0]   = data_i;
  assign b_sticky[0] = 1'b0;
  assign b_shamt[0]  = shamt_i;
  assign b_dir[0]    = dir_i;
  assign b_fill[0]   = arith_i & data_i[SW-1] & ~dir_i;
  assign b_valid[0]  = in_valid_i;
  assign in_ready_o  = b_ready[0];

  assign b_ready[LEVELS] = out_ready_i;
  assign out_valid_o     = b_valid[LEVELS];
  assign data_o          = b_data[LEVELS];
  assign sticky_o        = b_sticky[LEVELS];

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int            STEP     = 1 << k;
    localparam logic [SW-1:0] LOW_MASK = ~({SW{1'b1}} << STEP);

    logic [SW-1:0] c_data;
    logic          c_sticky;

    // Right shifts drop the low STEP bits into sticky; left shifts lose MSBs silently.
    always_comb begin
      c_data   = b_data[k];
      c_sticky = b_sticky[k];
      if (b_shamt[k][k]) begin
        if (b_dir[k]) begin
          c_data = b_data[k] << STEP;
        end else begin
          c_data   = (b_data[k] >> STEP) | ({SW{b_fill[k]}} & ~({SW{1'b1}} >> STEP));
          c_sticky = b_sticky[k] | (|(b_data[k] & LOW_MASK));
        end
      end
    end

    if (PIPE_MASK[k]) begin : g_reg
      logic [SW-1:0]     r_data;
      logic              r_sticky;
      logic [LEVELS-1:0] r_shamt;
      logic              r_dir;
      logic              r_fill;
      logic              r_valid;
      logic              load;

      // Empty or draining this cycle: drain and refill in the same cycle keeps full rate.
      assign load = ~r_valid | b_ready[k+1];

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_data   <= '0;
          r_sticky <= 1'b0;
          r_shamt  <= '0;
          r_dir    <= 1'b0;
          r_fill   <= 1'b0;
          r_valid  <= 1'b0;
        end else if (load) begin
          r_valid <= b_valid[k];
          if (b_valid[k]) begin
            r_data   <= c_data;
            r_sticky <= c_sticky;
            r_shamt  <= b_shamt[k];
            r_dir    <= b_dir[k];
            r_fill   <= b_fill[k];
          end
        end
      end

      assign b_ready[k]    = load;
      assign b_data[k+1]   = r_data;
      assign b_sticky[k+1] = r_sticky;
      assign b_shamt[k+1]  = r_shamt;
      assign b_dir[k+1]    = r_dir;
      assign b_fill[k+1]   = r_fill;
      assign b_valid[k+1]  = r_valid;
    end else begin : g_wire
      assign b_ready[k]    = b_ready[k+1];
      assign b_data[k+1]   = c_data;
      assign b_sticky[k+1] = c_sticky;
      assign b_shamt[k+1]  = b_shamt[k];
      assign b_dir[k+1]    = b_dir[k];
      assign b_fill[k+1]   = b_fill[k];
      assign b_valid[k+1]  = b_valid[k];
    end
  end

  logic unused_tail;
  assign unused_tail = ^{b_shamt[LEVELS], b_dir[LEVELS], b_fill[LEVELS]};

endmodule

// File: tb/tb_align_shifter_pipe.sv
// tb/tb_align_shifter_pipe.sv - randomized and directed checks of align_shifter_pipe
module tb_align_shifter_pipe;
  localparam int SW = 26;
  localparam int LV = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, dir, arith, out_valid, out_ready, sticky;
  logic [SW-1:0] data_in, data_out;
  logic [LV-1:0] shamt;

  logic          c_in_valid, c_in_ready, c_dir, c_arith, c_out_valid, c_out_ready, c_sticky;
  logic [SW-1:0] c_data_in, c_data_out;
  logic [LV-1:0] c_shamt;

  int tests_run = 0;
  int tests_failed = 0;

  align_shifter_pipe #(.SW(SW), .LEVELS(LV), .PIPE_MASK(5'b10101)) u_dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .data_i(data_in), .shamt_i(shamt), .dir_i(dir), .arith_i(arith),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .data_o(data_out), .sticky_o(sticky)
  );

  align_shifter_pipe #(.SW(SW), .LEVELS(LV), .PIPE_MASK(5'b00000)) u_comb (
    .clk(clk), .rst(rst), .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
    .data_i(c_data_in), .shamt_i(c_shamt), .dir_i(c_dir), .arith_i(c_arith),
    .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .data_o(c_data_out), .sticky_o(c_sticky)
  );

  // Reference: sign-extend (or zero-extend) to 64 bits, shift, and OR whatever fell off bit 0.
  function automatic void ref_shift(input logic [SW-1:0] d, input int s, input logic dr,
                                    input logic ar, output logic [SW-1:0] r, output logic st);
    logic [63:0] ext;
    logic [63:0] tmp;
    if (dr) begin
      tmp = 64'(d) << s;
      r   = tmp[SW-1:0];
      st  = 1'b0;
    end else begin
      ext = 64'(d);
      if (ar && d[SW-1]) ext = ext | ~((64'd1 << SW) - 64'd1);
      tmp = ext >> s;
      r   = tmp[SW-1:0];
      st  = |(ext & ((64'd1 << s) - 64'd1));
    end
  endfunction

  task automatic run_beat(input logic [SW-1:0] d, input logic [LV-1:0] s, input logic dr,
                          input logic ar, output logic [SW-1:0] od, output logic ost, output int lat);
    int waited;
    od  = '0;
    ost = 1'b0;
    lat = 99;
    @(negedge clk);
    in_valid = 1'b1; data_in = d; shamt = s; dir = dr; arith = ar; out_ready = 1'b1;
    #1;
    waited = 0;
    while (!in_ready && waited < 10) begin
      @(negedge clk); #1; waited++;
    end
    if (!in_ready) return;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        od = data_out; ost = sticky; lat = c;
        return;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests_run++;
    if (data_out !== '0) begin tests_failed++; $display("FAIL reset_data got %h exp 0", data_out); end
    tests_run++;
    if (sticky !== 1'b0) begin tests_failed++; $display("FAIL reset_sticky got %b exp 0", sticky); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_logical_right();
    logic [SW-1:0] od; logic ost; int lat;
    run_beat(26'h0000013, 5'd4, 1'b0, 1'b0, od, ost, lat);
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("FAIL lr_latency got %0d exp 3", lat); end
    tests_run++;
    if (od !== 26'h0000001 || ost !== 1'b1) begin
      tests_failed++; $display("FAIL lr_result got %h/%b exp 0000001/1", od, ost);
    end
  endtask

  task automatic test_left();
    logic [SW-1:0] od; logic ost; int lat;
    run_beat(26'h0000001, 5'd3, 1'b1, 1'b0, od, ost, lat);
    tests_run++;
    if (od !== 26'h0000008 || ost !== 1'b0 || lat !== 3) begin
      tests_failed++; $display("FAIL left_3 got %h/%b lat %0d exp 0000008/0 lat 3", od, ost, lat);
    end
    run_beat(26'h2000001, 5'd1, 1'b1, 1'b1, od, ost, lat);
    tests_run++;
    if (od !== 26'h0000002 || ost !== 1'b0) begin
      tests_failed++; $display("FAIL left_msb_loss got %h/%b exp 0000002/0", od, ost);
    end
  endtask

  task automatic test_arith_range();
    logic [SW-1:0] od; logic ost; int lat;
    run_beat(26'h2000000, 5'd25, 1'b0, 1'b1, od, ost, lat);
    tests_run++;
    if (od !== 26'h3FFFFFF || ost !== 1'b0) begin
      tests_failed++; $display("FAIL arith_25 got %h/%b exp 3ffffff/0", od, ost);
    end
    run_beat(26'h0000001, 5'd30, 1'b0, 1'b0, od, ost, lat);
    tests_run++;
    if (od !== 26'h0000000 || ost !== 1'b1) begin
      tests_failed++; $display("FAIL logic_30 got %h/%b exp 0000000/1", od, ost);
    end
    run_beat(26'h0ABCDEF, 5'd31, 1'b1, 1'b0, od, ost, lat);
    tests_run++;
    if (od !== 26'h0000000 || ost !== 1'b0) begin
      tests_failed++; $display("FAIL left_31 got %h/%b exp 0000000/0", od, ost);
    end
  endtask

  task automatic test_backpressure();
    logic [SW-1:0] ed; logic es;
    int next, got, gaps;
    logic take;
    next = 0; got = 0; gaps = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      @(negedge clk);
      out_ready = (c >= 6);
      dir = 1'b0; arith = 1'b0; data_in = 26'h3FFFFFF;
      in_valid = (next < 5);
      shamt = LV'(next);
      #1;
      if (c == 3) begin
        tests_run++;
        if (in_ready !== 1'b0 || next !== 3) begin
          tests_failed++; $display("FAIL bp_full in_ready %b accepted %0d exp 0 and 3", in_ready, next);
        end
      end
      if (c >= 3 && c <= 5) begin
        tests_run++;
        if (out_valid !== 1'b1 || data_out !== 26'h3FFFFFF || sticky !== 1'b0) begin
          tests_failed++; $display("FAIL bp_hold c%0d got %b/%h/%b exp 1/3ffffff/0", c, out_valid, data_out, sticky);
        end
      end
      take = in_valid && in_ready;
      if (out_valid && out_ready) begin
        ref_shift(26'h3FFFFFF, got, 1'b0, 1'b0, ed, es);
        tests_run++;
        if (data_out !== ed || sticky !== es) begin
          tests_failed++; $display("FAIL bp_order beat %0d got %h/%b exp %h/%b", got, data_out, sticky, ed, es);
        end
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      @(posedge clk);
      if (take) next++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (got !== 5 || gaps !== 0) begin
      tests_failed++; $display("FAIL bp_count got %0d beats %0d gaps exp 5 beats 0 gaps", got, gaps);
    end
  endtask

  task automatic test_reset_midflight();
    logic [SW-1:0] od; logic ost; int lat, stale;
    @(negedge clk);
    out_ready = 1'b1; dir = 1'b0; arith = 1'b0; shamt = 5'd1; data_in = 26'h0000FF0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_in = 26'h0000FF4;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || data_out !== '0 || sticky !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_clear got %b/%h/%b exp 0/0/0", out_valid, data_out, sticky);
    end
    rst = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    tests_run++;
    if (stale !== 0) begin tests_failed++; $display("FAIL midrst_stale got %0d exp 0", stale); end
    run_beat(26'h1234567, 5'd2, 1'b0, 1'b0, od, ost, lat);
    tests_run++;
    if (lat !== 3 || od !== 26'h048D159 || ost !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_first got %h/%b lat %0d exp 048d159/1 lat 3", od, ost, lat);
    end
  endtask

  task automatic test_random();
    logic [SW-1:0] q_d[$];
    logic          q_s[$];
    logic [SW-1:0] ed; logic es;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (c < 600) begin
        in_valid = ($urandom_range(0, 9) < 7);
        data_in  = SW'($urandom);
        shamt    = LV'($urandom);
        dir      = 1'($urandom);
        arith    = 1'($urandom);
        out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        tests_run++;
        if (q_d.size() == 0) begin
          tests_failed++; $display("FAIL rand_spurious got %h with empty scoreboard", data_out);
        end else begin
          ed = q_d.pop_front(); es = q_s.pop_front();
          if (data_out !== ed || sticky !== es) begin
            tests_failed++; $display("FAIL rand_beat got %h/%b exp %h/%b", data_out, sticky, ed, es);
          end
        end
      end
      if (in_valid && in_ready) begin
        ref_shift(data_in, int'(shamt), dir, arith, ed, es);
        q_d.push_back(ed); q_s.push_back(es);
      end
    end
    tests_run++;
    if (q_d.size() != 0) begin tests_failed++; $display("FAIL rand_drain left %0d exp 0", q_d.size()); end
  endtask

  task automatic test_comb();
    logic [SW-1:0] ed; logic es;
    @(negedge clk);
    c_in_valid = 1'b1; c_data_in = 26'h00000F0; c_shamt = 5'd4; c_dir = 1'b0; c_arith = 1'b0;
    c_out_ready = 1'b1;
    #1;
    tests_run++;
    if (c_out_valid !== 1'b1 || c_data_out !== 26'h000000F || c_sticky !== 1'b0 || c_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL comb_same_cycle got %b/%h/%b rdy %b exp 1/000000f/0 rdy 1", c_out_valid, c_data_out, c_sticky, c_in_ready);
    end
    c_out_ready = 1'b0;
    #1;
    tests_run++;
    if (c_in_ready !== 1'b0) begin tests_failed++; $display("FAIL comb_ready got %b exp 0", c_in_ready); end
    c_in_valid = 1'b0;
    #1;
    tests_run++;
    if (c_out_valid !== 1'b0) begin tests_failed++; $display("FAIL comb_valid got %b exp 0", c_out_valid); end
    for (int i = 0; i < 40; i++) begin
      c_data_in = SW'($urandom); c_shamt = LV'($urandom); c_dir = 1'($urandom); c_arith = 1'($urandom);
      #1;
      ref_shift(c_data_in, int'(c_shamt), c_dir, c_arith, ed, es);
      tests_run++;
      if (c_data_out !== ed || c_sticky !== es) begin
        tests_failed++; $display("FAIL comb_rand got %h/%b exp %h/%b", c_data_out, c_sticky, ed, es);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; data_in = '0; shamt = '0; dir = 1'b0; arith = 1'b0; out_ready = 1'b1;
    c_in_valid = 1'b0; c_data_in = '0; c_shamt = '0; c_dir = 1'b0; c_arith = 1'b0; c_out_ready = 1'b0;
    test_reset();
    test_logical_right();
    test_left();
    test_arith_range();
    test_backpressure();
    test_reset_midflight();
    test_random();
    test_comb();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
